// File: rtl/vga_timing_gen_pkg.sv
// Shared timing definitions: standard mode presets and the total-period derivation
// used by the VGA timing generator.
package vga_timing_gen_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fporch;
    int unsigned pulse;
    int unsigned bporch;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
    logic  h_pol;
    logic  v_pol;
  } preset_t;

  // Sync polarity: 0 = active-low, 1 = active-high.
  localparam preset_t XGA_60  = '{h: '{1024, 24, 136, 160}, v: '{768, 3, 6, 29},
                                  h_pol: 1'b0, v_pol: 1'b0};
  localparam preset_t SVGA_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23},
                                  h_pol: 1'b1, v_pol: 1'b1};
  localparam preset_t VGA_60  = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33},
                                  h_pol: 1'b0, v_pol: 1'b0};

  localparam int MAX_LOOKAHEAD = 15;

  function automatic int axis_total(input int act, input int fp, input int pw, input int bp);
    return act + fp + pw + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of the generator: fetch-side position plus display-side sync/position.
interface vga_timing_gen_if #(
  parameter int CW = 13
);
  logic          fetch_en;
  logic [CW-1:0] fetch_h;
  logic [CW-1:0] fetch_v;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          line_start;
  logic          frame_start;
  logic          vblank;

  modport master (
    output fetch_en, fetch_h, fetch_v, hsync, vsync, active, h, v,
           line_start, frame_start, vblank
  );

  modport slave (
    input fetch_en, fetch_h, fetch_v, hsync, vsync, active, h, v,
          line_start, frame_start, vblank
  );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Clock-enable gated shift register; carries fetch position and flags to the display stage.
module vga_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (ce_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters, fetch-position outputs, and a lookahead
// pipeline that delays the position to the display stage where sync/blank are decoded.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE  = XGA_60.h.active,
  parameter int H_FPORCH  = XGA_60.h.fporch,
  parameter int H_PULSE   = XGA_60.h.pulse,
  parameter int H_BPORCH  = XGA_60.h.bporch,
  parameter int V_ACTIVE  = XGA_60.v.active,
  parameter int V_FPORCH  = XGA_60.v.fporch,
  parameter int V_PULSE   = XGA_60.v.pulse,
  parameter int V_BPORCH  = XGA_60.v.bporch,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int LOOKAHEAD = 2,
  parameter int CW        = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  vga_timing_gen_if.master tim
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FPORCH, H_PULSE, H_BPORCH);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FPORCH, V_PULSE, V_BPORCH);
  localparam int DEPTH   = LOOKAHEAD + 1;
  localparam int DW      = 2 * CW + 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FPORCH);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FPORCH + H_PULSE - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FPORCH);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FPORCH + V_PULSE - 1);
  localparam logic          H_ASSERT = H_POL[0];
  localparam logic          V_ASSERT = V_POL[0];

  if (H_FPORCH == 0 || H_PULSE == 0 || H_BPORCH == 0 ||
      V_FPORCH == 0 || V_PULSE == 0 || V_BPORCH == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and pulse widths must be non-zero");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD > MAX_LOOKAHEAD) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must be in 0..15");
  end
  if (CW < 1 || CW > 30 || H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0] fetch_h_q, fetch_v_q;
  logic          fetch_en_q, fetch_vld_q, ce_seen_q;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // fetch_vld_q keeps the pre-reset filler out of the display decode until (0,0) arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q        <= '0;
      vc_q        <= '0;
      fetch_h_q   <= '0;
      fetch_v_q   <= '0;
      fetch_en_q  <= 1'b0;
      fetch_vld_q <= 1'b0;
      ce_seen_q   <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      ce_seen_q <= pix_ce;
      if (pix_ce) begin
        fetch_h_q   <= hc_q;
        fetch_v_q   <= vc_q;
        fetch_en_q  <= (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
        fetch_vld_q <= 1'b1;
      end
    end
  end

  logic [DW-1:0] pipe_d, pipe_q;
  logic          disp_vld;
  logic [CW-1:0] disp_h, disp_v;
  logic          in_hs, in_vs, line_start_w;

  assign pipe_d = {fetch_vld_q, fetch_h_q, fetch_v_q};

  vga_delay_line #(.W(DW), .DEPTH(DEPTH)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .ce_i (pix_ce),
    .d_i  (pipe_d),
    .q_o  (pipe_q)
  );

  assign {disp_vld, disp_h, disp_v} = pipe_q;

  assign in_hs        = disp_vld && (disp_h >= HS_FIRST) && (disp_h <= HS_LAST);
  assign in_vs        = disp_vld && (disp_v >= VS_FIRST) && (disp_v <= VS_LAST);
  // Strobes are qualified by the previous clock's enable so they last one clk, not one tick.
  assign line_start_w = ce_seen_q && disp_vld && (disp_h == '0);

  assign tim.fetch_en    = fetch_en_q;
  assign tim.fetch_h     = fetch_h_q;
  assign tim.fetch_v     = fetch_v_q;
  assign tim.h           = disp_h;
  assign tim.v           = disp_v;
  assign tim.hsync       = in_hs ? H_ASSERT : ~H_ASSERT;
  assign tim.vsync       = in_vs ? V_ASSERT : ~V_ASSERT;
  assign tim.active      = disp_vld && (disp_h < H_ACT_C) && (disp_v < V_ACT_C);
  assign tim.vblank      = disp_vld && (disp_v >= V_ACT_C);
  assign tim.line_start  = line_start_w;
  assign tim.frame_start = line_start_w && (disp_v == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small 16x8 raster plus an XGA-default instance.
module tb_vga_timing_gen;

  localparam int HT = 16;
  localparam int FT = 128;
  localparam int LA = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b1;

  vga_timing_gen_if #(.CW(13)) tim ();
  vga_timing_gen_if #(.CW(13)) tim_x ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FPORCH(2), .H_PULSE(3), .H_BPORCH(3),
    .V_ACTIVE(4), .V_FPORCH(1), .V_PULSE(2), .V_BPORCH(1),
    .H_POL(0), .V_POL(0), .LOOKAHEAD(LA), .CW(13)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .tim    (tim)
  );

  vga_timing_gen dut_x (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (1'b1),
    .tim    (tim_x)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pos     = 0;
  logic last_ce = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Display position is pos; fetch leads it by LOOKAHEAD+1 ticks.
  task automatic check_model();
    int hh, vv, fp, fh, fv;
    hh = pos % HT;
    vv = pos / HT;
    fp = (pos + LA + 1) % FT;
    fh = fp % HT;
    fv = fp / HT;
    check("h", 32'(tim.h), 32'(hh));
    check("v", 32'(tim.v), 32'(vv));
    check("active", 32'(tim.active), 32'(hh < 8 && vv < 4));
    check("hsync", 32'(tim.hsync), 32'(!(hh >= 10 && hh <= 12)));
    check("vsync", 32'(tim.vsync), 32'(!(vv >= 5 && vv <= 6)));
    check("vblank", 32'(tim.vblank), 32'(vv >= 4));
    check("line_start", 32'(tim.line_start), 32'(last_ce && hh == 0));
    check("frame_start", 32'(tim.frame_start), 32'(last_ce && pos == 0));
    check("fetch_h", 32'(tim.fetch_h), 32'(fh));
    check("fetch_v", 32'(tim.fetch_v), 32'(fv));
    check("fetch_en", 32'(tim.fetch_en), 32'(fh < 8 && fv < 4));
  endtask

  task automatic step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    @(negedge clk);
    if (ce) pos = (pos + 1) % FT;
    last_ce = ce;
    check_model();
  endtask

  initial begin
    int hs_low, vs_low, vb_hi, act_hi, ls_cnt, last_fs, fs_delay;
    int t1, t2, x_low, x_act;
    logic prev;

    // Reset state
    rst = 1'b1;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_h", 32'(tim.h), 0);
    check("rst_v", 32'(tim.v), 0);
    check("rst_fetch_h", 32'(tim.fetch_h), 0);
    check("rst_fetch_v", 32'(tim.fetch_v), 0);
    check("rst_active", 32'(tim.active), 0);
    check("rst_fetch_en", 32'(tim.fetch_en), 0);
    check("rst_hsync", 32'(tim.hsync), 1);
    check("rst_vsync", 32'(tim.vsync), 1);
    check("rst_line_start", 32'(tim.line_start), 0);
    check("rst_frame_start", 32'(tim.frame_start), 0);
    check("rst_vblank", 32'(tim.vblank), 0);

    // Pipeline fill after release
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        check("first_fetch_en", 32'(tim.fetch_en), 1);
        check("first_fetch_h", 32'(tim.fetch_h), 0);
        check("first_fetch_v", 32'(tim.fetch_v), 0);
      end
      if (e < 4) begin
        check("fill_active", 32'(tim.active), 0);
        check("fill_frame_start", 32'(tim.frame_start), 0);
      end
    end
    check("first_frame_start", 32'(tim.frame_start), 1);
    pos = 0;
    last_ce = 1'b1;
    check_model();

    // Two full frames at one pixel per clock
    hs_low = 0; vs_low = 0; vb_hi = 0; act_hi = 0; ls_cnt = 0; last_fs = 0;
    for (int t = 1; t <= 2 * FT; t++) begin
      step(1'b1);
      hs_low += int'(!tim.hsync);
      vs_low += int'(!tim.vsync);
      vb_hi  += int'(tim.vblank);
      act_hi += int'(tim.active);
      ls_cnt += int'(tim.line_start);
      if (tim.frame_start) begin
        check("frame_period", 32'(t - last_fs), 128);
        last_fs = t;
      end
    end
    check("hsync_low_clocks", 32'(hs_low), 48);
    check("vsync_low_clocks", 32'(vs_low), 64);
    check("vblank_clocks", 32'(vb_hi), 128);
    check("active_clocks", 32'(act_hi), 64);
    check("line_start_count", 32'(ls_cnt), 16);

    // Half-rate enable: 32 ticks from a frame start span two lines
    ls_cnt = 0;
    for (int j = 1; j <= 64; j++) begin
      step(j % 2 == 1);
      ls_cnt += int'(tim.line_start);
    end
    check("toggle_line_starts", 32'(ls_cnt), 2);

    // Reset in the middle of vsync (row 6)
    while (pos != 100) step(1'b1);
    rst = 1'b1;
    pix_ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_vsync", 32'(tim.vsync), 1);
    check("midrst_hsync", 32'(tim.hsync), 1);
    check("midrst_h", 32'(tim.h), 0);
    check("midrst_v", 32'(tim.v), 0);
    check("midrst_active", 32'(tim.active), 0);
    check("midrst_frame_start", 32'(tim.frame_start), 0);
    rst = 1'b0;
    fs_delay = 0;
    for (int e = 1; e <= 20 && fs_delay == 0; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (tim.frame_start) fs_delay = e;
      else check("midrst_no_vsync", 32'(tim.vsync), 1);
    end
    check("midrst_fs_delay", 32'(fs_delay), 32'(LA + 2));
    pos = 0;
    last_ce = 1'b1;
    for (int t = 0; t < 40; t++) step(1'b1);

    // XGA defaults: one hsync period measured falling edge to falling edge
    t1 = -1; t2 = -1; x_low = 0; x_act = 0;
    prev = tim_x.hsync;
    for (int c = 0; c < 4000 && t2 < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (prev && !tim_x.hsync) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
      if (t1 >= 0 && t2 < 0) begin
        x_low += int'(!tim_x.hsync);
        x_act += int'(tim_x.active);
      end
      prev = tim_x.hsync;
    end
    check("xga_hsync_period", 32'(t2 - t1), 1344);
    check("xga_hsync_width", 32'(x_low), 136);
    check("xga_active_per_line", 32'(x_act), 1024);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
